// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, FSM states,
// flag bit positions, ACC source encodings and the opcode classifier.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_LDB = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h4;
   localparam logic [3:0] OP_ALU = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_Z = 1;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_MEM,
      ST_EXEC,
      ST_HALT
   } state_t;

   typedef enum logic [1:0] {
      ACC_SRC_ALU = 2'd0,
      ACC_SRC_MEM = 2'd1,
      ACC_SRC_IMM = 2'd2
   } acc_src_t;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_LOAD_A,
      CLS_LOAD_B,
      CLS_STORE,
      CLS_IMM,
      CLS_ALU,
      CLS_BRANCH,
      CLS_HALT
   } op_class_t;

   // Opcodes 9..E are reserved and execute as NOP.
   function automatic op_class_t classify(input logic [3:0] op);
      case (op)
         OP_LDA:               return CLS_LOAD_A;
         OP_LDB:               return CLS_LOAD_B;
         OP_STA:               return CLS_STORE;
         OP_LDI:               return CLS_IMM;
         OP_ALU:               return CLS_ALU;
         OP_JMP, OP_JC, OP_JZ: return CLS_BRANCH;
         OP_HLT:               return CLS_HALT;
         default:              return CLS_NOP;
      endcase
   endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decode: opcode class, branch resolution against
// the latched flags, branch target and data-page address.
module instr_decode
   import cpu_pkg::*;
#(
   parameter logic [3:0] DATA_PAGE = 4'hF
) (
   input  logic [7:0] ir,
   input  logic [1:0] flags,
   output op_class_t  op_class,
   output logic       branch_taken,
   output logic [7:0] branch_target,
   output logic [7:0] data_addr
);

   logic [3:0] opcode;
   logic [3:0] operand;

   assign opcode        = ir[7:4];
   assign operand       = ir[3:0];
   assign op_class      = classify(opcode);
   assign branch_target = {operand, 4'h0};
   assign data_addr     = {DATA_PAGE, operand};

   always_comb begin
      branch_taken = 1'b0;
      case (opcode)
         OP_JMP:  branch_taken = 1'b1;
         OP_JC:   branch_taken = flags[FLAG_C];
         OP_JZ:   branch_taken = flags[FLAG_Z];
         default: branch_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC/HALT controller for the 8-bit CPU.
// All strobes are decoded combinationally from the state register and IR.
module control_unit
   import cpu_pkg::*;
#(
   parameter logic [7:0] PC_RESET  = 8'h00,
   parameter logic [3:0] DATA_PAGE = 4'hF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ready,
   input  logic [7:0] alu_flag,
   output logic [7:0] mem_addr,
   output logic       mem_rd,
   output logic       mem_we,
   output logic [3:0] alu_sel,
   output logic       acc_we,
   output logic [1:0] acc_src,
   output logic       b_we,
   output logic [7:0] imm,
   output logic [7:0] pc,
   output logic [1:0] flags,
   output logic       halted
);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] pc_q;
   logic [7:0] ir_q;
   logic [1:0] flags_q;

   op_class_t  op_class;
   logic       branch_taken;
   logic [7:0] branch_target;
   logic [7:0] data_addr;

   logic [5:0] unused_alu_flag;
   assign unused_alu_flag = alu_flag[7:2];

   instr_decode #(
      .DATA_PAGE(DATA_PAGE)
   ) u_decode (
      .ir           (ir_q),
      .flags        (flags_q),
      .op_class     (op_class),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .data_addr    (data_addr)
   );

   assign pc    = pc_q;
   assign flags = flags_q;
   assign imm   = {4'h0, ir_q[3:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_FETCH;
         pc_q    <= PC_RESET;
         ir_q    <= '0;
         flags_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_FETCH: begin
               if (mem_ready) begin
                  ir_q <= mem_rdata;
                  pc_q <= pc_q + 8'd1;
               end
            end
            ST_DECODE: begin
               if (branch_taken) pc_q <= branch_target;
            end
            ST_EXEC: begin
               flags_q[FLAG_Z] <= alu_flag[FLAG_Z];
               flags_q[FLAG_C] <= alu_flag[FLAG_C];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      mem_addr  = pc_q;
      mem_rd    = 1'b0;
      mem_we    = 1'b0;
      alu_sel   = ir_q[3:0];
      acc_we    = 1'b0;
      acc_src   = ACC_SRC_ALU;
      b_we      = 1'b0;
      halted    = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            case (op_class)
               CLS_IMM: begin
                  acc_we    = 1'b1;
                  acc_src   = ACC_SRC_IMM;
                  state_nxt = ST_FETCH;
               end
               CLS_LOAD_A, CLS_LOAD_B, CLS_STORE: state_nxt = ST_MEM;
               CLS_ALU:                           state_nxt = ST_EXEC;
               CLS_HALT:                          state_nxt = ST_HALT;
               default:                           state_nxt = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            // Request stays up until the memory completes; load strobes fire only then.
            mem_addr = data_addr;
            mem_rd   = (op_class != CLS_STORE);
            mem_we   = (op_class == CLS_STORE);
            if (mem_ready) begin
               if (op_class == CLS_LOAD_A) begin
                  acc_we  = 1'b1;
                  acc_src = ACC_SRC_MEM;
               end
               b_we      = (op_class == CLS_LOAD_B);
               state_nxt = ST_FETCH;
            end
         end
         ST_EXEC: begin
            alu_sel   = ir_q[3:0];
            acc_we    = 1'b1;
            acc_src   = ACC_SRC_ALU;
            state_nxt = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: state_nxt = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level model builds the
// expected per-cycle outputs, one compare process checks them at negedge.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] mem_rdata;
   logic       mem_ready = 1'b0;
   logic [7:0] alu_flag = 8'h00;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic       mem_we;
   logic [3:0] alu_sel;
   logic       acc_we;
   logic [1:0] acc_src;
   logic       b_we;
   logic [7:0] imm;
   logic [7:0] pc;
   logic [1:0] flags;
   logic       halted;

   logic [7:0] mem_arr [256];

   control_unit #(
      .PC_RESET (8'h00),
      .DATA_PAGE(4'hF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .alu_flag (alu_flag),
      .mem_addr (mem_addr),
      .mem_rd   (mem_rd),
      .mem_we   (mem_we),
      .alu_sel  (alu_sel),
      .acc_we   (acc_we),
      .acc_src  (acc_src),
      .b_we     (b_we),
      .imm      (imm),
      .pc       (pc),
      .flags    (flags),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_arr[mem_addr];

   typedef struct packed {
      logic [7:0] addr;
      logic       rd;
      logic       we;
      logic [3:0] sel;
      logic       acc_we;
      logic [1:0] src;
      logic       chk_src;
      logic       b_we;
      logic [7:0] imm;
      logic [7:0] pc;
      logic [1:0] flags;
      logic       halted;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   int   rd_ff_cnt = 0;

   // Architectural model state
   logic [7:0] m_pc;
   logic [7:0] m_ir;
   logic [1:0] m_flags;   // {zero, carry}
   logic       m_halt;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         exp_t a;
         e = exp_q.pop_front();
         a = '{addr: mem_addr, rd: mem_rd, we: mem_we, sel: alu_sel, acc_we: acc_we,
               src: acc_src, chk_src: e.chk_src, b_we: b_we, imm: imm, pc: pc,
               flags: flags, halted: halted};
         if (!e.chk_src) a.src = e.src;
         checks++;
         if (a === e) passes++;
         else $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a, e);
      end
      if (mem_rd === 1'b1 && mem_addr === 8'hFF) rd_ff_cnt++;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   task automatic cyc(input logic rdy, input logic [7:0] af, input exp_t e);
      mem_ready = rdy;
      alu_flag  = af;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t base();
      exp_t e;
      e = '{addr: m_pc, rd: 1'b0, we: 1'b0, sel: m_ir[3:0], acc_we: 1'b0, src: 2'd0,
            chk_src: 1'b0, b_we: 1'b0, imm: {4'h0, m_ir[3:0]}, pc: m_pc,
            flags: m_flags, halted: 1'b0};
      return e;
   endfunction

   task automatic model_reset();
      m_pc = 8'h00; m_ir = 8'h00; m_flags = 2'b00; m_halt = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
   endtask

   // One instruction: fw/mw extra not-ready cycles in fetch/memory phases.
   task automatic step(input int fw, input int mw, input logic [7:0] af, input bit rst_mid);
      exp_t e;
      logic [3:0] op;
      logic [3:0] opr;
      if (m_halt) begin
         e = base(); e.halted = 1'b1;
         cyc(1'b1, af, e);
         return;
      end
      for (int i = 0; i <= fw; i++) begin
         e = base(); e.rd = 1'b1;
         cyc(i == fw, 8'h00, e);
      end
      m_ir = mem_arr[m_pc];
      m_pc = m_pc + 8'd1;
      op  = m_ir[7:4];
      opr = m_ir[3:0];
      e = base();
      if (op == 4'h4) begin e.acc_we = 1'b1; e.src = 2'd2; e.chk_src = 1'b1; end
      cyc(1'b1, 8'h00, e);
      if (op == 4'h6 || (op == 4'h7 && m_flags[0]) || (op == 4'h8 && m_flags[1]))
         m_pc = {opr, 4'h0};
      if (op >= 4'h1 && op <= 4'h3) begin
         for (int i = 0; i <= mw; i++) begin
            e = base();
            e.addr = {4'hF, opr};
            e.rd = (op != 4'h3);
            e.we = (op == 4'h3);
            if (i == mw) begin
               if (op == 4'h1) begin e.acc_we = 1'b1; e.src = 2'd1; e.chk_src = 1'b1; end
               if (op == 4'h2) e.b_we = 1'b1;
            end
            cyc(i == mw, 8'h00, e);
            if (rst_mid) begin
               rst = 1'b1;
               mem_ready = 1'b0;
               @(posedge clk); #1;
               chk("rst_mem_we", {7'd0, mem_we}, 8'h00);
               chk("rst_pc", pc, 8'h00);
               chk("rst_flags", {6'd0, flags}, 8'h00);
               chk("rst_fetch_rd", {7'd0, mem_rd}, 8'h01);
               rst = 1'b0;
               model_reset();
               return;
            end
         end
      end
      if (op == 4'h5) begin
         e = base(); e.sel = opr; e.acc_we = 1'b1; e.src = 2'd0; e.chk_src = 1'b1;
         cyc(1'b1, af, e);
         m_flags = {af[1], af[0]};
      end
      if (op == 4'hF) m_halt = 1'b1;
   endtask

   initial begin
      int rd0;
      model_reset();
      clear_mem();

      // LDI / ALU / HLT
      mem_arr[0] = 8'h41; mem_arr[1] = 8'h56; mem_arr[2] = 8'hF0;
      do_reset();
      chk("reset_pc", pc, 8'h00);
      chk("reset_alu_sel", {4'h0, alu_sel}, 8'h00);
      step(0, 0, 8'h00, 0);
      chk("ldi_imm", imm, 8'h01);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
      chk("halt_pc", pc, 8'h03);
      chk("halted", {7'd0, halted}, 8'h01);

      // LDA with three wait cycles in MEM
      clear_mem();
      mem_arr[0] = 8'h1F; mem_arr[1] = 8'hF0; mem_arr[8'hFF] = 8'h5A;
      do_reset();
      rd0 = rd_ff_cnt;
      step(0, 3, 8'h00, 0);
      chk("lda_rd_cycles", 8'(rd_ff_cnt - rd0), 8'h04);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      // Conditional branches
      clear_mem();
      mem_arr[8'h00] = 8'h50; mem_arr[8'h01] = 8'h73;
      mem_arr[8'h30] = 8'h50; mem_arr[8'h31] = 8'h73; mem_arr[8'h32] = 8'h83;
      do_reset();
      step(0, 0, 8'h01, 0);
      step(0, 0, 8'h00, 0);
      chk("jc_taken_pc", pc, 8'h30);
      step(0, 0, 8'h02, 0);
      step(0, 0, 8'h00, 0);
      chk("jc_not_taken_pc", pc, 8'h32);
      step(0, 0, 8'h00, 0);
      chk("jz_taken_pc", pc, 8'h30);

      // Reserved opcodes, LDB/STA with waits, PC wrap
      clear_mem();
      mem_arr[8'h00] = 8'h53; mem_arr[8'h01] = 8'h6F;
      mem_arr[8'hF0] = 8'h90; mem_arr[8'hF1] = 8'hA1; mem_arr[8'hF2] = 8'hB2;
      mem_arr[8'hF3] = 8'hC3; mem_arr[8'hF4] = 8'hD4; mem_arr[8'hF5] = 8'hE5;
      mem_arr[8'hF6] = 8'h2A; mem_arr[8'hF7] = 8'h3B;
      do_reset();
      step(0, 0, 8'h03, 0);
      step(0, 0, 8'h00, 0);
      chk("jmp_pc", pc, 8'hF0);
      step(2, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0);
      step(0, 1, 8'h00, 0);
      step(0, 2, 8'h00, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 0);
      chk("wrap_pc", pc, 8'h00);
      chk("nop_flags", {6'd0, flags}, 8'h03);

      // Reset in the middle of a store
      clear_mem();
      mem_arr[8'h00] = 8'h53; mem_arr[8'h01] = 8'h35;
      do_reset();
      step(0, 0, 8'h01, 0);
      step(0, 2, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      @(posedge clk); #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
